// File: rtl/pipeline_skid_buffer_if.sv
// Valid/ready handshake bundle for pipeline_skid_buffer: upstream insert side and downstream remove side.
// The master modport is the environment around the block; the slave modport is the block itself.
interface pipeline_skid_buffer_if #(
  parameter int WORD_WIDTH = 0
);
  logic                  input_valid;
  logic                  input_ready;
  logic [WORD_WIDTH-1:0] input_data;
  logic                  output_valid;
  logic                  output_ready;
  logic [WORD_WIDTH-1:0] output_data;

  modport master (
    output input_valid,
    input  input_ready,
    output input_data,
    input  output_valid,
    output output_ready,
    input  output_data
  );

  modport slave (
    input  input_valid,
    output input_ready,
    input  input_data,
    output output_valid,
    input  output_ready,
    output output_data
  );
endinterface

// File: rtl/pipeline_skid_buffer.sv
// Two-entry valid/ready skid buffer: registered input_ready and output_valid break every
// combinational path between the upstream and downstream handshakes at full throughput.

module pipeline_skid_buffer_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      data_q <= '0;
    end else if (enable_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;
endmodule

module pipeline_skid_buffer #(
  parameter int WORD_WIDTH = 0
) (
  input  logic                         clock,
  input  logic                         clear,
  pipeline_skid_buffer_if.slave        bus
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic input_ready_q;
  logic input_ready_d;
  logic output_valid_q;
  logic output_valid_d;

  logic insert;
  logic remove;

  logic                  main_load;
  logic                  main_from_skid;
  logic                  skid_load;
  logic [WORD_WIDTH-1:0] main_d;
  logic [WORD_WIDTH-1:0] main_q;
  logic [WORD_WIDTH-1:0] skid_q;

  assign insert = bus.input_valid & input_ready_q;
  assign remove = output_valid_q & bus.output_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (insert) begin
          main_load = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (insert && remove) begin
          main_load = 1'b1;
        end else if (insert) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (remove) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (remove) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Handshake flags follow the next state so they are valid straight out of a flop.
  assign input_ready_d  = (state_d != ST_FULL);
  assign output_valid_d = (state_d == ST_BUSY) || (state_d == ST_FULL);
  assign main_d         = main_from_skid ? skid_q : bus.input_data;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q        <= ST_EMPTY;
      input_ready_q  <= 1'b1;
      output_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      input_ready_q  <= input_ready_d;
      output_valid_q <= output_valid_d;
    end
  end

  pipeline_skid_buffer_reg #(.WIDTH(WORD_WIDTH)) u_main_reg (
    .clock    (clock),
    .clear    (clear),
    .enable_i (main_load),
    .data_i   (main_d),
    .data_o   (main_q)
  );

  pipeline_skid_buffer_reg #(.WIDTH(WORD_WIDTH)) u_skid_reg (
    .clock    (clock),
    .clear    (clear),
    .enable_i (skid_load),
    .data_i   (bus.input_data),
    .data_o   (skid_q)
  );

  assign bus.input_ready  = input_ready_q;
  assign bus.output_valid = output_valid_q;
  assign bus.output_data  = main_q;
endmodule
